// File: rtl/peripheral_bin2bcd_pkg.sv
// Shared definitions for the binary/BCD conversion peripherals:
// register offsets, default sizes and the conversion FSM states.
package peripheral_bin2bcd_pkg;

    localparam int DEF_WIDTH  = 17;
    localparam int DEF_DIGITS = 6;

    localparam logic [4:0] ADDR_A    = 5'h04;
    localparam logic [4:0] ADDR_INIT = 5'h0C;
    localparam logic [4:0] ADDR_DATA = 5'h10;
    localparam logic [4:0] ADDR_DONE = 5'h14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/peripheral_bin2bcd_core.sv
// bin2bcd: sequential double-dabble core, one operand bit per clock.
// Ports: clk, reset (sync, high), start, a (operand), result (packed BCD), done (sticky).
module bin2bcd
    import peripheral_bin2bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      a,
    output logic [4*DIGITS-1:0]   result,
    output logic                  done
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    state_e          state_q, state_d;
    logic [SW-1:0]   sh_q, sh_d, adj;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   result_q, result_d;
    logic            done_q, done_d;

    // BCD digits sit above the operand bits; correct each one before the shift.
    always_comb begin
        adj = sh_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sh_q[WIDTH+4*i +: 4] >= 4'd5)
                adj[WIDTH+4*i +: 4] = sh_q[WIDTH+4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = done_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d    = {{BW{1'b0}}, a};
                    cnt_d   = CW'(WIDTH);
                    done_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sh_d  = {adj[SW-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = DONE;
            end
            DONE: begin
                result_d = sh_q[SW-1:WIDTH];
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: rtl/peripheral_bin2bcd.sv
// J1 bus peripheral: binary operand in, packed BCD out (double-dabble core).
// Ports: clk, reset (sync, high), d_in/cs/addr/rd/wr bus inputs, d_out registered read data.
module peripheral_bin2bcd
    import peripheral_bin2bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out
);

    logic [WIDTH-1:0]    a_q;
    logic                start_q;
    logic [4*DIGITS-1:0] result;
    logic                done;
    logic                wr_en, rd_en;
    logic [31:0]         rd_data;
    logic                unused_din;

    // Simultaneous rd+wr counts as a write only.
    assign wr_en = cs & wr;
    assign rd_en = cs & rd & ~wr;

    assign unused_din = ^d_in;

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_DATA: rd_data = 32'(result);
            ADDR_DONE: rd_data = {31'b0, done};
            default:   rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            start_q <= 1'b0;
            d_out   <= '0;
        end else begin
            if (wr_en && addr == ADDR_A)
                a_q <= d_in[WIDTH-1:0];
            start_q <= wr_en && (addr == ADDR_INIT) && d_in[0];
            if (rd_en)
                d_out <= rd_data;
        end
    end

    bin2bcd #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) bin2bcd0 (
        .clk    (clk),
        .reset  (reset),
        .start  (start_q),
        .a      (a_q),
        .result (result),
        .done   (done)
    );

endmodule

// File: tb/tb_peripheral_bin2bcd.sv
// Self-checking bench for peripheral_bin2bcd.
// Bus-level stimulus against a decimal-digit reference model.
module tb_peripheral_bin2bcd;

    localparam logic [4:0] A_OFF    = 5'h04;
    localparam logic [4:0] INIT_OFF = 5'h0C;
    localparam logic [4:0] DATA_OFF = 5'h10;
    localparam logic [4:0] DONE_OFF = 5'h14;
    localparam int         LAT      = 19;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] d_in = '0;
    logic        cs = 1'b0;
    logic [4:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] d_out;

    int total = 0;
    int bad   = 0;

    peripheral_bin2bcd dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic bus_write(input logic [4:0] ad, input logic [19:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = ad; d_in = d;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] ad, output logic [31:0] q);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = ad;
        @(posedge clk);
        #1;
        q = d_out;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Counts edges until done is seen high; 100 means it never came.
    task automatic wait_done(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (dut.bin2bcd0.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic run_conv(input int v, input string tag);
        int          n;
        logic [31:0] q;
        bus_write(A_OFF, 20'(v));
        bus_write(INIT_OFF, 20'd1);
        wait_done(n);
        total++;
        if (n !== LAT) begin
            bad++;
            $display("FAIL %s latency: got %0d edges, want %0d", tag, n, LAT);
        end
        bus_read(DONE_OFF, q);
        total++;
        if (q !== 32'd1) begin
            bad++;
            $display("FAIL %s done: got %h, want 1", tag, q);
        end
        bus_read(DATA_OFF, q);
        total++;
        if (q !== ref_bcd(v)) begin
            bad++;
            $display("FAIL %s result: got %h, want %h", tag, q, ref_bcd(v));
        end
    endtask

    task automatic test_reset();
        logic [31:0] q;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if (d_out !== 32'd0) begin
            bad++;
            $display("FAIL reset d_out: got %h, want 0", d_out);
        end
        bus_read(DATA_OFF, q);
        total++;
        if (q !== 32'd0) begin
            bad++;
            $display("FAIL reset result: got %h, want 0", q);
        end
        bus_write(INIT_OFF, 20'd0);
        repeat (25) @(posedge clk);
        #1;
        bus_read(DONE_OFF, q);
        total++;
        if (q !== 32'd0) begin
            bad++;
            $display("FAIL reset done after init0: got %h, want 0", q);
        end
    endtask

    task automatic test_fixed();
        run_conv(32'h1E240, "op_123456");
        run_conv(32'h1869F, "op_99999");
        run_conv(32'h1FFFF, "op_max");
        run_conv(0, "op_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_conv(int'($urandom_range(0, 131071)), "op_rand");
    endtask

    task automatic test_operand_change();
        int          n;
        bit          seen;
        logic [31:0] q;
        bus_write(A_OFF, 20'd5);
        bus_write(INIT_OFF, 20'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            n++;
            @(negedge clk);
            if (n == 5) begin
                cs = 1'b1; wr = 1'b1; addr = A_OFF; d_in = 20'd9;
            end else if (n == 6) begin
                cs = 1'b1; wr = 1'b1; addr = INIT_OFF; d_in = 20'd1;
            end else begin
                cs = 1'b0; wr = 1'b0;
            end
            @(posedge clk);
            #1;
            if (dut.bin2bcd0.done === 1'b1) seen = 1'b1;
        end
        cs = 1'b0; wr = 1'b0;
        total++;
        if (n !== LAT) begin
            bad++;
            $display("FAIL midchange latency: got %0d, want %0d", n, LAT);
        end
        bus_read(DATA_OFF, q);
        total++;
        if (q !== ref_bcd(5)) begin
            bad++;
            $display("FAIL midchange result: got %h, want %h", q, ref_bcd(5));
        end
        bus_write(INIT_OFF, 20'd1);
        wait_done(n);
        bus_read(DATA_OFF, q);
        total++;
        if (q !== ref_bcd(9)) begin
            bad++;
            $display("FAIL newA result: got %h, want %h", q, ref_bcd(9));
        end
    endtask

    task automatic test_init_zero();
        logic [31:0] q;
        bus_write(INIT_OFF, 20'd0);
        repeat (25) @(posedge clk);
        #1;
        bus_read(DONE_OFF, q);
        total++;
        if (q !== 32'd1) begin
            bad++;
            $display("FAIL init0 done: got %h, want 1", q);
        end
        bus_read(DATA_OFF, q);
        total++;
        if (q !== ref_bcd(9)) begin
            bad++;
            $display("FAIL init0 result: got %h, want %h", q, ref_bcd(9));
        end
        bus_read(5'h08, q);
        total++;
        if (q !== 32'd0) begin
            bad++;
            $display("FAIL read 0x08: got %h, want 0", q);
        end
    endtask

    task automatic test_wr_rd_both();
        logic [31:0] q;
        bus_read(DONE_OFF, q);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = DATA_OFF; d_in = 20'h12345;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        total++;
        if (d_out !== 32'd1) begin
            bad++;
            $display("FAIL rd+wr hold: got %h, want 1", d_out);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q;
        bus_write(A_OFF, 20'h1E240);
        bus_write(INIT_OFF, 20'd1);
        repeat (5) @(posedge clk);
        pulse_reset();
        total++;
        if (d_out !== 32'd0) begin
            bad++;
            $display("FAIL midreset d_out: got %h, want 0", d_out);
        end
        bus_read(DONE_OFF, q);
        total++;
        if (q !== 32'd0) begin
            bad++;
            $display("FAIL midreset done: got %h, want 0", q);
        end
        bus_read(DATA_OFF, q);
        total++;
        if (q !== 32'd0) begin
            bad++;
            $display("FAIL midreset result: got %h, want 0", q);
        end
        repeat (25) @(posedge clk);
        #1;
        bus_read(DONE_OFF, q);
        total++;
        if (q !== 32'd0) begin
            bad++;
            $display("FAIL midreset aborted done: got %h, want 0", q);
        end
        run_conv(32'h03039, "op_12345");
    endtask

    task automatic test_back_to_back();
        logic [31:0] q;
        int          n;
        for (int i = 0; i < 10; i++) begin
            bus_read(DONE_OFF, q);
            total++;
            if (q !== 32'd1) begin
                bad++;
                $display("FAIL sticky done %0d: got %h, want 1", i, q);
            end
        end
        bus_write(INIT_OFF, 20'd1);
        bus_read(DONE_OFF, q);
        total++;
        if (q !== 32'd1) begin
            bad++;
            $display("FAIL done at start sample: got %h, want 1", q);
        end
        bus_read(DONE_OFF, q);
        total++;
        if (q !== 32'd0) begin
            bad++;
            $display("FAIL done after start: got %h, want 0", q);
        end
        wait_done(n);
        total++;
        if (n !== LAT - 2) begin
            bad++;
            $display("FAIL b2b latency: got %0d, want %0d", n, LAT - 2);
        end
        bus_read(DATA_OFF, q);
        total++;
        if (q !== ref_bcd(32'h03039)) begin
            bad++;
            $display("FAIL b2b result: got %h, want %h", q, ref_bcd(32'h03039));
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_random();
        test_operand_change();
        test_init_zero();
        test_wr_rd_both();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
